// File: rtl/monobit_pkg.sv
// Shared types and constants for the monobit byte feeder.
// Optional drop counter build macro: MONOBIT_FEEDER_DROP_CNT_EN.
package monobit_pkg;

  localparam int MONOBIT_BLOCK_BITS_DEFAULT = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_t;

  // Block counter width; never narrower than one bit.
  function automatic int blk_cnt_width(input int block_bits);
    return (block_bits > 2) ? $clog2(block_bits) : 1;
  endfunction

endpackage

// File: rtl/monobit_byte_feeder_if.sv
// Serialized bit stream from the feeder to the monobit test core.
interface monobit_byte_feeder_if;
  logic bit_out;
  logic bit_valid;
  logic bit_ready;
  logic bit_first;
  logic bit_last;

  modport master (
    output bit_out, bit_valid, bit_first, bit_last,
    input  bit_ready
  );

  modport slave (
    input  bit_out, bit_valid, bit_first, bit_last,
    output bit_ready
  );
endinterface

// File: rtl/monobit_strobe_sync.sv
// Two-flop synchronizer for an asynchronous strobe followed by a
// single-cycle rising-edge pulse generator.
module monobit_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= strobe;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/monobit_byte_feeder.sv
// Captures strobed bytes into a 2-entry FIFO and serializes them MSB-first
// with block framing. Optional drop counter: MONOBIT_FEEDER_DROP_CNT_EN.
module monobit_byte_feeder
  import monobit_pkg::*;
#(
  parameter int BLOCK_BITS = MONOBIT_BLOCK_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [7:0]            din,
  input  logic                  din_strobe,
  monobit_byte_feeder_if.master bit_if,
  output logic [1:0]            fifo_level,
  output logic                  overflow
`ifdef MONOBIT_FEEDER_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  localparam int CW = blk_cnt_width(BLOCK_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLOCK_BITS - 1);

  logic strobe_pulse;
  logic push_req;
  logic push;
  logic pop;
  logic drop;

  logic [7:0]    fifo_mem [2];
  logic          fifo_wr_ptr_reg;
  logic          fifo_rd_ptr_reg;
  logic [1:0]    fifo_level_reg;
  logic [1:0]    fifo_level_next;
  logic [7:0]    fifo_head;
  logic          overflow_reg;

  feeder_state_t state_reg, state_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic [3:0]    bits_left_reg, bits_left_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  monobit_strobe_sync u_strobe_sync (
    .clk    (clk),
    .rst    (rst),
    .strobe (din_strobe),
    .pulse  (strobe_pulse)
  );

  // A full FIFO can still take a byte when the serializer pops in the same cycle.
  assign push_req  = strobe_pulse & ena;
  assign push      = push_req & ((fifo_level_reg != 2'd2) | pop);
  assign drop      = push_req & ~push;
  assign fifo_head = fifo_mem[fifo_rd_ptr_reg];

  always_comb begin
    fifo_level_next = fifo_level_reg;
    case ({push, pop})
      2'b10:   fifo_level_next = fifo_level_reg + 2'd1;
      2'b01:   fifo_level_next = fifo_level_reg - 2'd1;
      default: fifo_level_next = fifo_level_reg;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    bits_left_next = bits_left_reg;
    cnt_next       = cnt_reg;
    pop            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_level_reg != 2'd0) begin
          pop            = 1'b1;
          shreg_next     = fifo_head;
          bits_left_next = 4'd8;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_if.bit_ready) begin
          cnt_next = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + 1'b1;
          if (bits_left_reg == 4'd1) begin
            // Reload straight from the FIFO so byte boundaries carry no bubble.
            if (fifo_level_reg != 2'd0) begin
              pop            = 1'b1;
              shreg_next     = fifo_head;
              bits_left_next = 4'd8;
            end else begin
              shreg_next     = '0;
              bits_left_next = 4'd0;
              state_next     = IDLE;
            end
          end else begin
            shreg_next     = {shreg_reg[6:0], 1'b0};
            bits_left_next = bits_left_reg - 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      shreg_reg       <= '0;
      bits_left_reg   <= '0;
      cnt_reg         <= '0;
      fifo_wr_ptr_reg <= 1'b0;
      fifo_rd_ptr_reg <= 1'b0;
      fifo_level_reg  <= 2'd0;
      overflow_reg    <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      state_reg       <= state_next;
      shreg_reg       <= shreg_next;
      bits_left_reg   <= bits_left_next;
      cnt_reg         <= cnt_next;
      fifo_wr_ptr_reg <= fifo_wr_ptr_reg ^ push;
      fifo_rd_ptr_reg <= fifo_rd_ptr_reg ^ pop;
      fifo_level_reg  <= fifo_level_next;
      overflow_reg    <= overflow_reg | drop;
      if (push) fifo_mem[fifo_wr_ptr_reg] <= din;
    end
  end

`ifdef MONOBIT_FEEDER_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_reg <= 8'd0;
    end else if (drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

  assign bit_if.bit_valid = (state_reg == SHIFT);
  assign bit_if.bit_out   = shreg_reg[7];
  assign bit_if.bit_first = (state_reg == SHIFT) && (cnt_reg == '0);
  assign bit_if.bit_last  = (state_reg == SHIFT) && (cnt_reg == CNT_MAX);
  assign fifo_level       = fifo_level_reg;
  assign overflow         = overflow_reg;

endmodule
